// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and types for the multiply/divide unit
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negation (abs on input, sign fix on output)
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  // Feeding the operand's own sign bit as neg_i turns this into abs()
  assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand for multiply, divisor for divide
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  // neg_lo covers the product (multiply) or the quotient (divide); neg_hi the remainder
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 op_div, op_signed;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Decode the operation class and signedness
  always_comb begin
    op_div    = 1'b0;
    op_signed = 1'b0;
    case (op)
      OP_MULT:  op_signed = 1'b1;
      OP_MULTU: op_signed = 1'b0;
      OP_DIV:   begin op_div = 1'b1; op_signed = 1'b1; end
      OP_DIVU:  op_div = 1'b1;
      default:  op_signed = 1'b0;
    endcase
  end

  muldiv_signfix #(.W(WIDTH)) u_abs_a (
    .val_i(a), .neg_i(op_signed & a[WIDTH-1]), .val_o(a_abs));
  muldiv_signfix #(.W(WIDTH)) u_abs_b (
    .val_i(b), .neg_i(op_signed & b[WIDTH-1]), .val_o(b_abs));
  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .val_i(acc_q), .neg_i(neg_lo_q), .val_o(prod_fix));
  muldiv_signfix #(.W(WIDTH)) u_fix_quo (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_lo_q), .val_o(quo_fix));
  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_hi_q), .val_o(rem_fix));

  // Shift-add: add multiplicand into the upper half when the multiplier LSB is set, then shift right
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring division: shift in the next dividend bit and keep the subtraction if it did not borrow
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_step  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Next-state, datapath and HI/LO update selection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CALC;
          cnt_d      = 6'(WIDTH);
          is_div_d   = op_div;
          neg_lo_d   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_hi_d   = op_signed & a[WIDTH-1];
          dbz_pend_d = op_div & (b == {WIDTH{1'b0}});
          opnd_d     = op_div ? b_abs : a_abs;
          acc_d      = {{WIDTH{1'b0}}, (op_div ? a_abs : b_abs)};
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      ST_CALC: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = ST_FIX;
      end
      ST_FIX: begin
        // With a zero divisor the remainder path already reproduces the dividend
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = dbz_pend_q ? {WIDTH{1'b1}} : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        dbz_d   = dbz_pend_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 6'd0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result from plain arithmetic
  task automatic model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] ehi, output logic [31:0] elo, output logic edbz);
    longint      ps;
    logic [63:0] pu;
    int          sa, sb;
    edbz = 1'b0;
    case (o)
      2'b00: begin
        ps  = longint'($signed(av)) * longint'($signed(bv));
        pu  = 64'(ps);
        ehi = pu[63:32];
        elo = pu[31:0];
      end
      2'b01: begin
        pu  = {32'd0, av} * {32'd0, bv};
        ehi = pu[63:32];
        elo = pu[31:0];
      end
      default: begin
        if (bv == 32'd0) begin
          ehi = av; elo = 32'hFFFF_FFFF; edbz = 1'b1;
        end else if (o == 2'b11) begin
          elo = av / bv; ehi = av % bv;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          elo = 32'h8000_0000; ehi = 32'd0;
        end else begin
          sa = av; sb = bv;
          elo = 32'(sa / sb); ehi = 32'(sa % sb);
        end
      end
    endcase
  endtask

  // Issue one operation (entered just after a falling edge) and check timing and result
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input bit disturb, input bit lo_with_start, input string tag);
    logic [31:0] ehi, elo, hi0, lo0;
    logic        edbz;
    bit          win_ok;
    model(o, av, bv, ehi, elo, edbz);
    hi0 = hi; lo0 = lo;
    op = o; a = av; b = bv; start = 1'b1;
    lo_we = lo_with_start; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    win_ok = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
      end
      if (!(busy === 1'b1 && done === 1'b0 && hi === hi0 && lo === lo0)) win_ok = 1'b0;
      if (disturb && i == 5) begin
        start = 1'b1; op = 2'b01; a = 32'h0000_0002; b = 32'h0000_0003;
        hi_we = 1'b1; wdata = 32'h0000_1234;
      end
      if (disturb && i == 6) begin
        start = 1'b0; hi_we = 1'b0;
      end
    end
    chk({tag, " busy window"}, 64'(win_ok), 64'd1);
    @(negedge clk);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " busy at done"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(ehi));
    chk({tag, " lo"}, 64'(lo), 64'(elo));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          quiet;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu max");
    chk("multu max hi const", 64'(hi), 64'hFFFF_FFFE);
    chk("multu max lo const", 64'(lo), 64'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, "mult -3x5");
    chk("mult -3x5 lo const", 64'(lo), 64'hFFFF_FFF1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, "mult minsq");
    chk("mult minsq hi const", 64'(hi), 64'h4000_0000);
    run_op(2'b11, 32'd100, 32'd7, 0, 0, "divu 100/7");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, "div -7/2");
    chk("div -7/2 hi const", 64'(hi), 64'hFFFF_FFFF);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0, "div 7/-2");
    chk("div 7/-2 lo const", 64'(lo), 64'hFFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div ovf");
    chk("div ovf lo const", 64'(lo), 64'h8000_0000);

    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, "busy ignore");
    run_op(2'b11, 32'd1000, 32'd10, 0, 1, "start+lo_we");

    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); @(negedge clk);
    hi_we = 1'b0;
    chk("mthi hi", 64'(hi), 64'h0000_1234);
    chk("mthi lo kept", 64'(lo), 64'd100);
    chk("mthi no done", 64'(done), 64'd0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55AA_33CC;
    @(posedge clk); @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi+mtlo hi", 64'(hi), 64'h55AA_33CC);
    chk("mthi+mtlo lo", 64'(lo), 64'h55AA_33CC);

    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 200);
      run_op(ro, ra, rb, 0, 0, $sformatf("rand%0d", n));
    end

    run_op(2'b11, 32'd5, 32'd0, 0, 0, "divu 5/0");
    repeat (3) @(negedge clk);
    chk("dbz held", 64'(div_by_zero), 64'd1);

    op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    chk("abort dbz", 64'(div_by_zero), 64'd0);
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("abort no done", 64'(quiet), 64'd1);
    run_op(2'b01, 32'd3, 32'd4, 0, 0, "multu 3x4");
    chk("multu 3x4 lo const", 64'(lo), 64'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath. It consumes the two register-file read operands (A = rs, B = rt) on the execute stage and implements MULT, MULTU, DIV and DIVU into private HI/LO registers. It also supports direct HI/LO writes (MTHI/MTLO) and exposes HI/LO continuously for MFHI/MFLO write-back into the register file. It uses one result bit per cycle and asserts `busy` so the control path can stall dependent instructions.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits.

- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  request an operation; accepted only when `busy`=0
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  in  WIDTH  operand rs (multiplicand / dividend)
- `b`  in  WIDTH  operand rt (multiplier / divisor)
- `hi_we`  in  1  MTHI: load HI from `wdata`
- `lo_we`  in  1  MTLO: load LO from `wdata`
- `wdata`  in  WIDTH  data for MTHI/MTLO
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse when HI/LO hold a new result
- `div_by_zero`  out  1  valid with `done`; set for DIV/DIVU with `b`=0
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE + `start` → CALC. Latch `op`, |a|, |b| (absolute values for signed ops; raw values for unsigned), the result-sign bits and a 6-bit iteration counter set to WIDTH.
  - CALC: one iteration per cycle; counter decrements. When the counter reaches 1, the next state is FIX.
  - FIX: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
- Multiply uses a shift-add over a 2·WIDTH accumulator. Signed product is negated as a full 64-bit value if sign(a)≠sign(b). HI = upper half, LO = lower half.
- Divide uses restoring division, LO = quotient, HI = remainder.
  - Signed quotient is negated if the signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero: HI = `a`, LO = all ones, `div_by_zero`=1 (both DIV and DIVU).
- Signed overflow 0x80000000 / −1 produces LO = 0x80000000, HI = 0, with no flag.
- MTHI/MTLO:
  - Honoured only in IDLE with `start`=0; HI/LO update on the next edge.
  - Ignored while `busy` is high.
  - If `start` and `hi_we`/`lo_we` are asserted together, `start` wins and the write is dropped.
  - `hi_we` and `lo_we` together write both registers.
- `start` while `busy` is ignored; no queueing.
- `div_by_zero` holds its value until the next `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, state IDLE.
- Reset mid-operation aborts the operation. The next cycle shows the reset values, with no `done` pulse.
- For `start` sampled at edge k:
  - `busy` is high after edge k through edge k+32.
  - CALC runs for edges k+1..k+32.
  - FIX is on edge k+33: HI/LO are updated, `done`=1 for one cycle, and `busy`=0 in that same cycle.
- A new `start` may be sampled in the `done` cycle (back-to-back operations, 34-cycle spacing).
- `hi`/`lo` are stable registers; the intermediate accumulator is never visible on them.
- `a`/`b`/`op` need only be valid on the `start` edge.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`)
  - FSM state typedef
  - `WIDTH` default constant
- One combinational sub-module `muldiv_signfix`: conditional absolute value on input and conditional two's-complement negation on output. It is parameterised by width and used for both the 32-bit and the 64-bit cases.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 34 cycles after the `start` edge; `busy` high for cycles 1–33.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIVU 100/7 → LO=14, HI=2; DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 7/−2 → LO=0xFFFFFFFD, HI=1.
- DIVU 5/0 → HI=5, LO=0xFFFFFFFF, `div_by_zero`=1; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, `div_by_zero`=0.
- While `busy`, pulse `start` with new operands and pulse `hi_we` with `wdata`=0x1234 → both ignored and the original result is delivered. In IDLE, `hi_we`=1 with `wdata`=0x1234 → `hi`=0x1234 next cycle. `start`+`lo_we` together → divide runs and LO is not written by `wdata`.
- Assert `reset` for one cycle at cycle 10 of a DIVU → next cycle `busy`=0, `hi`=`lo`=0, and no `done` pulse. A following MULTU 3×4 yields LO=12, HI=0 at cycle 34.
